// File: rtl/packet_assembler_pkg.sv
// Shared constants and the BCH step used by the HDMI data-island packet assembler.
// The step is the LSB-first LFSR form of the generator polynomial 0x83.
package packet_assembler_pkg;

  localparam logic [7:0] BCH_POLY    = 8'h83;
  localparam int         PACKET_LEN  = 32;
  localparam int         HEADER_BITS = 24;
  localparam int         SUB_BITS    = 56;

  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    bch_step = (ecc >> 1) ^ ((ecc[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/packet_assembler_bch_ecc_accumulator.sv
// 8-bit BCH parity register that absorbs one or two message bits per pixel.
// In two-bit mode the even bit is folded in before the odd bit.
module bch_ecc_accumulator
  import packet_assembler_pkg::*;
#(
  parameter bit TWO_BITS = 1'b0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_even,
  input  logic       bit_odd,
  output logic [7:0] ecc
);

  logic [7:0] ecc_next;

  always_comb begin
    ecc_next = bch_step(ecc, bit_even);
    if (TWO_BITS) begin
      ecc_next = bch_step(ecc_next, bit_odd);
    end
  end

  // Clear wins over enable so the end-of-packet wipe is never lost.
  always_ff @(posedge clk_pixel) begin
    if (reset || clear) begin
      ecc <= 8'h00;
    end else if (enable) begin
      ecc <= ecc_next;
    end
  end

endmodule

// File: rtl/packet_assembler.sv
// Serialises one 32-pixel HDMI data-island packet (header + four subpackets)
// and appends BCH parity computed while the payload bits stream out.
module packet_assembler
  import packet_assembler_pkg::*;
(
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic         data_island_period,
  input  logic [23:0]  header,
  input  logic [223:0] sub,
  output logic [8:0]   packet_data,
  output logic [4:0]   counter
);

  logic        last_pos;
  logic        ecc_clear;
  logic        hdr_en;
  logic        sub_en;
  logic [7:0]  hdr_ecc;
  logic [55:0] sub_word [4];
  logic [7:0]  sub_ecc  [4];
  logic [5:0]  even_idx;
  logic [5:0]  odd_idx;

  assign last_pos  = (counter == 5'(PACKET_LEN - 1));
  assign ecc_clear = ~data_island_period | last_pos;
  assign hdr_en    = data_island_period & (counter < 5'(HEADER_BITS));
  assign sub_en    = data_island_period & (counter < 5'(SUB_BITS / 2));
  assign even_idx  = {counter, 1'b0};
  assign odd_idx   = {counter, 1'b1};

  // Wraps 31->0 naturally through the 5-bit width.
  always_ff @(posedge clk_pixel) begin
    if (reset || !data_island_period) begin
      counter <= 5'd0;
    end else begin
      counter <= counter + 5'd1;
    end
  end

  bch_ecc_accumulator #(.TWO_BITS(1'b0)) u_hdr_ecc (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .clear     (ecc_clear),
    .enable    (hdr_en),
    .bit_even  (header[counter]),
    .bit_odd   (1'b0),
    .ecc       (hdr_ecc)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sub
    assign sub_word[g] = sub[SUB_BITS*g +: SUB_BITS];

    bch_ecc_accumulator #(.TWO_BITS(1'b1)) u_sub_ecc (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .clear     (ecc_clear),
      .enable    (sub_en),
      .bit_even  (sub_word[g][even_idx]),
      .bit_odd   (sub_word[g][odd_idx]),
      .ecc       (sub_ecc[g])
    );
  end

  // For c>=24 the header parity index is c-24 == c[2:0]; for c>=28 the
  // subpacket parity pair index is c-28 == c[1:0].
  always_comb begin
    packet_data = '0;
    if (counter < 5'(HEADER_BITS)) begin
      packet_data[0] = header[counter];
    end else begin
      packet_data[0] = hdr_ecc[counter[2:0]];
    end
    for (int i = 0; i < 4; i++) begin
      if (counter < 5'(SUB_BITS / 2)) begin
        packet_data[1+i] = sub_word[i][even_idx];
        packet_data[5+i] = sub_word[i][odd_idx];
      end else begin
        packet_data[1+i] = sub_ecc[i][{counter[1:0], 1'b0}];
        packet_data[5+i] = sub_ecc[i][{counter[1:0], 1'b1}];
      end
    end
  end

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_packet_assembler;

  logic         clk_pixel = 1'b0;
  logic         reset = 1'b1;
  logic         data_island_period = 1'b0;
  logic [23:0]  header = '0;
  logic [223:0] sub = '0;
  logic [8:0]   packet_data;
  logic [4:0]   counter;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_pkt [32];

  always #5 clk_pixel = ~clk_pixel;

  packet_assembler dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .packet_data        (packet_data),
    .counter            (counter)
  );

  function automatic logic [7:0] model_step(input logic [7:0] e, input logic b);
    model_step = (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  // Reference packet built straight from the bit-mapping description.
  task automatic build_expected(input logic [23:0] h, input logic [223:0] s);
    logic [7:0]  he;
    logic [7:0]  se [4];
    logic [55:0] sw [4];
    he = 8'h00;
    for (int c = 0; c < 24; c++) he = model_step(he, h[c]);
    for (int i = 0; i < 4; i++) begin
      sw[i] = s[56*i +: 56];
      se[i] = 8'h00;
      for (int c = 0; c < 28; c++) begin
        se[i] = model_step(se[i], sw[i][2*c]);
        se[i] = model_step(se[i], sw[i][2*c+1]);
      end
    end
    for (int c = 0; c < 32; c++) begin
      exp_pkt[c][0] = (c < 24) ? h[c] : he[c-24];
      for (int i = 0; i < 4; i++) begin
        exp_pkt[c][1+i] = (c < 28) ? sw[i][2*c]   : se[i][2*(c-28)];
        exp_pkt[c][5+i] = (c < 28) ? sw[i][2*c+1] : se[i][2*(c-28)+1];
      end
    end
  endtask

  function automatic logic [223:0] rand_sub();
    logic [223:0] v;
    for (int k = 0; k < 7; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Called 1ns after a rising edge; runs positions 0..n-1 with the island high.
  task automatic run_packet(input string name, input logic [23:0] h,
                            input logic [223:0] s, input int n);
    header = h;
    sub = s;
    data_island_period = 1'b1;
    build_expected(h, s);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_pixel);
      checks++;
      if (counter !== 5'(c)) begin
        errors++;
        $display("FAIL %s counter at pos %0d: got %0d expected %0d", name, c, counter, c);
      end
      checks++;
      if (packet_data !== exp_pkt[c]) begin
        errors++;
        $display("FAIL %s packet_data at pos %0d: got %h expected %h", name, c, packet_data, exp_pkt[c]);
      end
      if (c != n - 1) begin
        @(posedge clk_pixel);
        #1;
      end
    end
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    data_island_period = 1'b0;
    repeat (n) @(posedge clk_pixel);
    #1;
  endtask

  task automatic test_reset();
    header = '0;
    sub = '0;
    reset = 1'b1;
    data_island_period = 1'b1;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    checks++;
    if (counter !== 5'd0) begin
      errors++;
      $display("FAIL reset counter: got %0d expected 0", counter);
    end
    checks++;
    if (packet_data !== 9'd0) begin
      errors++;
      $display("FAIL reset packet_data: got %h expected 000", packet_data);
    end
    reset = 1'b0;
    data_island_period = 1'b0;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic test_zero_packet();
    run_packet("zero_pkt", 24'h0, 224'h0, 32);
    // Island still high: the counter must have wrapped back to 0.
    @(negedge clk_pixel);
    checks++;
    if (counter !== 5'd0) begin
      errors++;
      $display("FAIL zero_pkt wrap counter: got %0d expected 0", counter);
    end
    @(posedge clk_pixel);
    #1;
    idle_cycles(2);
  endtask

  task automatic test_header_single();
    logic [31:0] ch0_stream;
    ch0_stream = {8'h4A, 24'h000001};
    header = 24'h000001;
    sub = '0;
    data_island_period = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk_pixel);
      checks++;
      if (packet_data !== {8'h00, ch0_stream[c]}) begin
        errors++;
        $display("FAIL hdr_single pos %0d: got %h expected %h", c, packet_data, {8'h00, ch0_stream[c]});
      end
      @(posedge clk_pixel);
      #1;
    end
    idle_cycles(2);
  endtask

  task automatic test_subpacket2();
    logic [223:0] s;
    s = '0;
    s[112] = 1'b1;
    header = '0;
    sub = s;
    data_island_period = 1'b1;
    @(negedge clk_pixel);
    checks++;
    if (packet_data !== 9'b000001000) begin
      errors++;
      $display("FAIL sub2 pos 0: got %h expected 008", packet_data);
    end
    @(posedge clk_pixel);
    #1;
    idle_cycles(1);
    run_packet("sub2", 24'h0, s, 32);
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [23:0]  h1, h2;
    logic [223:0] s1, s2;
    h1 = 24'($urandom);
    h2 = 24'($urandom);
    s1 = rand_sub();
    s2 = rand_sub();
    run_packet("b2b_1", h1, s1, 32);
    run_packet("b2b_2", h2, s2, 32);
    idle_cycles(2);
  endtask

  task automatic test_island_drop();
    logic [23:0]  h;
    logic [223:0] s;
    h = 24'hA5C3_7E;
    s = rand_sub();
    run_packet("drop_part", h, s, 13);
    data_island_period = 1'b0;
    @(negedge clk_pixel);
    checks++;
    if (counter !== 5'd13) begin
      errors++;
      $display("FAIL drop hold counter: got %0d expected 13", counter);
    end
    @(posedge clk_pixel);
    #1;
    data_island_period = 1'b1;
    @(negedge clk_pixel);
    checks++;
    if (counter !== 5'd0) begin
      errors++;
      $display("FAIL drop restart counter: got %0d expected 0", counter);
    end
    @(posedge clk_pixel);
    #1;
    // Counter is now 1; drop for one cycle to realign to position 0.
    idle_cycles(1);
    run_packet("drop_full", h, s, 32);
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    logic [23:0]  h;
    logic [223:0] s;
    h = 24'h3C_915B;
    s = rand_sub();
    run_packet("rst_part", h, s, 20);
    reset = 1'b1;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    run_packet("rst_after", h, s, 32);
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_zero_packet();
    test_header_single();
    test_subpacket2();
    test_back_to_back();
    test_island_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_assembler.md
# packet_assembler

Serialises one 32-cycle HDMI data-island packet from a parallel header and four subpackets, appending BCH parity computed on the fly. It sits directly downstream of the packet picker: it consumes `header`/`sub` and returns the pixel counter that the picker uses as `packet_pixel_counter`. It drives the 9 data-island bits per pixel that feed the TERC4 encoders.

## Interface
- No parameters.
- `clk_pixel` input 1: pixel clock; the only clock.
- `reset` input 1: synchronous, active-high.
- `data_island_period` input 1: high on every pixel of a data-island payload; asserted in runs that are multiples of 32.
- `header` input 24: packet header (HB0..HB2); stable for the whole packet.
- `sub` input 224: four subpackets; subpacket i is `sub[56*i +: 56]`; stable for the whole packet.
- `packet_data` output 9: per-pixel island bits; combinational from `counter`, inputs and the parity registers.
- `counter` output 5: position within the current packet (0..31).

## Operation
- Counter:
  - `counter` increments on each cycle with `data_island_period` high, wrapping 31→0.
  - It is forced to 0 on any cycle with `data_island_period` low.
- Bit selection, with c = `counter`:
  - `packet_data[0]` (channel 0, bit 2) = `header[c]` for c<24, else `hdr_ecc[c-24]`.
  - `packet_data[1+i]` (i=0..3) = even bit of subpacket i: `sub_i[2c]` for c<28, else `sub_ecc_i[2(c-28)]`.
  - `packet_data[5+i]` = odd bit of subpacket i: `sub_i[2c+1]` for c<28, else `sub_ecc_i[2(c-28)+1]`.
- BCH step function: `ecc' = (ecc >> 1) ^ ((ecc[0] ^ b) ? 8'h83 : 8'h00)`, 8-bit registers, initial value 0.
- Header parity, BCH(32,24): on clock edges with `data_island_period` high and c<24, `hdr_ecc <= step(hdr_ecc, header[c])`.
- Subpacket parity, BCH(64,56), four independent registers: on clock edges with `data_island_period` high and c<28, `sub_ecc_i <= step(step(sub_ecc_i, sub_i[2c]), sub_i[2c+1])`. The even bit is applied first.
- End of packet: on the edge leaving c=31, all five parity registers clear to 0 for the next packet.
- Idle: with `data_island_period` low, all parity registers are held at 0.
- `packet_data` is not qualified by `data_island_period`. The encoder ignores it outside the island.

## Timing
- Reset values: `counter`=0 and all parity registers 0. With `header`=0 and `sub`=0, `packet_data`=0.
- Output latency is zero cycles: the bit for position c appears in the same cycle `counter`==c.
- Parity availability:
  - The last header update is on the edge leaving c=23, so the complete `hdr_ecc` is valid from c=24 through c=31.
  - The last subpacket update is on the edge leaving c=27, so each `sub_ecc_i` is valid from c=28 through c=31.
- Counter-to-input turnaround: the picker updates `header`/`sub` on the edge where c goes 31→0. The new packet is therefore stable from c=0.
- `data_island_period` falling mid-packet: `counter` and parity clear on the next edge. There is no partial-packet state.
- `reset` mid-packet: same clearing as above; `reset` takes priority over `data_island_period`.
- Back-to-back packets: 31→0 wraps without a gap, and the parity clear and the next packet's first update do not conflict. At c=31 the registers clear; the c=0 update happens on the following edge.

## Structure
- Shared package: the polynomial constant `8'h83`, `PACKET_LEN=32`, `HEADER_BITS=24`, `SUB_BITS=56`, and the `bch_step` function.
- One sub-module is natural: `bch_ecc_accumulator`, an 8-bit register plus the step logic with a 1- or 2-bit input per cycle, instantiated five times (one header, four subpackets).

## Test plan
- Reset, then 32 cycles of island with `header`=0 and `sub`=0 → `packet_data`=0 every cycle; `counter` runs 0..31 and wraps.
- `header`=24'h000001, `sub`=0 → `packet_data[0]`=1 at c=0 and 0 at c=1..23. `hdr_ecc`=8'h4A, so c=24..31 carries 0,1,0,1,0,0,1,0.
- `sub` subpacket 2 = 56'h1, others 0 → `packet_data[3]`=1 at c=0. At c=28..31, `packet_data[3]`/`[7]` match a bench `bch_step` model fed 56 bits, even bit first. Subpackets 0, 1 and 3 stay 0.
- Two back-to-back packets with different random `header`/`sub` → both match the model; packet 2's parity is independent of packet 1's.
- `data_island_period` dropped at c=13, then restarted → `counter` is 0 on the restart cycle; the full packet's parity matches the model.
- `reset` asserted at c=20 with island high → next cycle `counter`=0 and parity cleared; the following packet is correct.
